// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART frame transmitter among N_CLIENTS requesters.
// Latches the granted client's frame, runs the framer start/busy/done handshake, reports done/reject.
module uart_tx_arbiter #(
    parameter int N_CLIENTS      = 4,
    parameter int BYTE_SIZE      = 8,
    parameter int MAX_MSG_LEN    = 8,
    parameter int DATA_SIZE      = MAX_MSG_LEN * BYTE_SIZE,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [N_CLIENTS-1:0]           i_req,
    input  logic [N_CLIENTS*BYTE_SIZE-1:0] i_opt,
    input  logic [N_CLIENTS*BYTE_SIZE-1:0] i_len,
    input  logic [N_CLIENTS*DATA_SIZE-1:0] i_data,
    output logic [N_CLIENTS-1:0]           o_gnt,
    output logic [N_CLIENTS-1:0]           o_done,
    output logic [N_CLIENTS-1:0]           o_rej,
    output logic [1:0]                     o_err_code,
    output logic                           o_tx_start,
    output logic [BYTE_SIZE-1:0]           o_tx_opt,
    output logic [BYTE_SIZE-1:0]           o_tx_len,
    output logic [DATA_SIZE-1:0]           o_tx_data,
    input  logic                           i_tx_busy,
    input  logic                           i_tx_done
);

    localparam int PTR_W = $clog2(N_CLIENTS);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [PTR_W-1:0] IDX_LAST = PTR_W'(N_CLIENTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_DONE,
        S_REJECT
    } state_e;

    state_e                 state_q;
    logic [PTR_W-1:0]       idx_q;
    logic [PTR_W-1:0]       ptr_q;
    logic [CNT_W-1:0]       cnt_q;

    logic                   sel_vld_d;
    logic [PTR_W-1:0]       sel_idx_d;
    logic [PTR_W-1:0]       ptr_d;
    logic [N_CLIENTS-1:0]   idx_oh;
    logic [BYTE_SIZE-1:0]   sel_opt;
    logic [BYTE_SIZE-1:0]   sel_len;
    logic [DATA_SIZE-1:0]   sel_data;
    logic                   len_bad;

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        int j;
        j         = 0;
        sel_vld_d = 1'b0;
        sel_idx_d = ptr_q;
        for (int k = 0; k < N_CLIENTS; k++) begin
            j = (int'(ptr_q) + k) % N_CLIENTS;
            if (!sel_vld_d && i_req[j]) begin
                sel_vld_d = 1'b1;
                sel_idx_d = PTR_W'(j);
            end
        end
    end

    assign ptr_d    = (idx_q == IDX_LAST) ? '0 : idx_q + PTR_W'(1);
    assign idx_oh   = N_CLIENTS'(1) << idx_q;
    assign sel_opt  = i_opt[idx_q*BYTE_SIZE +: BYTE_SIZE];
    assign sel_len  = i_len[idx_q*BYTE_SIZE +: BYTE_SIZE];
    assign sel_data = i_data[idx_q*DATA_SIZE +: DATA_SIZE];
    assign len_bad  = (sel_len == '0) || (32'(sel_len) > MAX_MSG_LEN);

    // Terminal pulses are raised on the transition into DONE/REJECT so they
    // appear the cycle after the deciding input is sampled.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            o_gnt      <= '0;
            o_done     <= '0;
            o_rej      <= '0;
            o_err_code <= '0;
            o_tx_start <= 1'b0;
            o_tx_opt   <= '0;
            o_tx_len   <= '0;
            o_tx_data  <= '0;
        end else begin
            o_tx_start <= 1'b0;
            o_done     <= '0;
            o_rej      <= '0;
            case (state_q)
                S_IDLE: begin
                    if (sel_vld_d) begin
                        idx_q   <= sel_idx_d;
                        o_gnt   <= N_CLIENTS'(1) << sel_idx_d;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    o_tx_opt  <= sel_opt;
                    o_tx_len  <= sel_len;
                    o_tx_data <= sel_data;
                    if (len_bad) begin
                        o_gnt      <= '0;
                        o_rej      <= idx_oh;
                        o_err_code <= 2'd1;
                        ptr_q      <= ptr_d;
                        state_q    <= S_REJECT;
                    end else begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (!i_tx_busy) begin
                        o_tx_start <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (i_tx_done) begin
                        o_gnt   <= '0;
                        o_done  <= idx_oh;
                        ptr_q   <= ptr_d;
                        state_q <= S_DONE;
                    end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
                        o_gnt      <= '0;
                        o_rej      <= idx_oh;
                        o_err_code <= 2'd2;
                        ptr_q      <= ptr_d;
                        state_q    <= S_REJECT;
                    end
                end
                S_DONE, S_REJECT: state_q <= S_IDLE;
                default:          state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: main instance with a 16-cycle timeout,
// second instance with the timeout disabled.
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int B = 8;
    localparam int M = 8;
    localparam int D = M * B;

    logic CLK = 1'b0;
    logic RST;
    logic [N-1:0]   req, req2, gnt, gnt2, done_o, done2, rej, rej2;
    logic [N*B-1:0] opt, len;
    logic [N*D-1:0] data;
    logic           busy, txdone, txdone2, start, start2;
    logic [1:0]     err, err2;
    logic [B-1:0]   topt, topt2, tlen, tlen2;
    logic [D-1:0]   tdata, tdata2;

    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0;

    always #5 CLK = ~CLK;
    always @(negedge CLK) if (start) start_cnt++;

    uart_tx_arbiter #(.N_CLIENTS(N), .BYTE_SIZE(B), .MAX_MSG_LEN(M), .TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RST(RST), .i_req(req), .i_opt(opt), .i_len(len), .i_data(data),
        .o_gnt(gnt), .o_done(done_o), .o_rej(rej), .o_err_code(err), .o_tx_start(start),
        .o_tx_opt(topt), .o_tx_len(tlen), .o_tx_data(tdata), .i_tx_busy(busy), .i_tx_done(txdone)
    );

    uart_tx_arbiter #(.N_CLIENTS(N), .BYTE_SIZE(B), .MAX_MSG_LEN(M), .TIMEOUT_CYCLES(0)) dut_nto (
        .CLK(CLK), .RST(RST), .i_req(req2), .i_opt(opt), .i_len(len), .i_data(data),
        .o_gnt(gnt2), .o_done(done2), .o_rej(rej2), .o_err_code(err2), .o_tx_start(start2),
        .o_tx_opt(topt2), .o_tx_len(tlen2), .o_tx_data(tdata2), .i_tx_busy(busy), .i_tx_done(txdone2)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Wait for grant, wait for start, then pulse done; returns what was observed.
    task automatic serve(output logic [N-1:0] g, output logic [N-1:0] d, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < 8 && gnt == '0; i++) tick();
        g = gnt;
        if (gnt == '0) ok = 1'b0;
        for (int i = 0; i < 50 && !start; i++) tick();
        if (!start) ok = 1'b0;
        txdone = 1'b1;
        tick();
        d = done_o;
        txdone = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) tick();
        n_cmp++; if ({gnt, done_o, rej} !== '0) begin n_bad++; $display("FAIL reset_hs: got %h want 0", {gnt, done_o, rej}); end
        n_cmp++; if ({err, start} !== '0) begin n_bad++; $display("FAIL reset_err_start: got %h want 0", {err, start}); end
        n_cmp++; if ({topt, tlen, tdata} !== '0) begin n_bad++; $display("FAIL reset_tx: got %h want 0", {topt, tlen, tdata}); end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int sc;
        logic [N-1:0] g, d;
        bit ok;
        len[2*B +: B]  = 8'd3;
        opt[2*B +: B]  = 8'hA5;
        data[2*D +: D] = 64'h1122_3300_0000_0000;
        req = 4'b0100;
        tick();
        n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL single_gnt: got %b want 0100", gnt); end
        tick();
        n_cmp++; if (tlen !== 8'd3 || topt !== 8'hA5) begin n_bad++; $display("FAIL single_tx_fields: got len %0d opt %h want 3 a5", tlen, topt); end
        n_cmp++; if (tdata !== 64'h1122_3300_0000_0000) begin n_bad++; $display("FAIL single_tx_data: got %h want 1122330000000000", tdata); end
        n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL single_start_early: got %b want 0", start); end
        sc = start_cnt;
        tick();
        n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL single_start: got %b want 1", start); end
        repeat (9) tick();
        n_cmp++; if (start_cnt - sc !== 1 || done_o !== '0) begin n_bad++; $display("FAIL single_one_start: got starts %0d done %b want 1 0000", start_cnt - sc, done_o); end
        txdone = 1'b1;
        tick();
        txdone = 1'b0;
        n_cmp++; if (done_o !== 4'b0100 || gnt !== '0) begin n_bad++; $display("FAIL single_done: got done %b gnt %b want 0100 0000", done_o, gnt); end
        req = '0;
        tick();
        n_cmp++; if (done_o !== '0) begin n_bad++; $display("FAIL single_done_width: got %b want 0000", done_o); end
        len[2*B +: B] = 8'd2;
        // Pointer should now be 3: of {0,2,3} client 3 wins.
        req = 4'b1101;
        serve(g, d, ok);
        n_cmp++; if (!ok || g !== 4'b1000 || d !== 4'b1000) begin n_bad++; $display("FAIL single_ptr3: got gnt %b done %b ok %0d want 1000 1000 1", g, d, ok); end
        req = '0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        logic [N-1:0] g, d;
        bit ok;
        req = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            serve(g, d, ok);
            n_cmp++; if (!ok || g !== exp_g[i]) begin n_bad++; $display("FAIL rr_gnt[%0d]: got %b ok %0d want %b", i, g, ok, exp_g[i]); end
            n_cmp++; if (d !== exp_g[i]) begin n_bad++; $display("FAIL rr_done[%0d]: got %b want %b", i, d, exp_g[i]); end
        end
        req = '0;
        tick();
    endtask

    task automatic test_bad_len();
        logic [B-1:0] bad [2] = '{8'd0, 8'd9};
        int sc;
        sc = start_cnt;
        for (int i = 0; i < 2; i++) begin
            len[1*B +: B] = bad[i];
            req = 4'b0010;
            tick();
            n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL badlen_gnt[%0d]: got %b want 0010", i, gnt); end
            tick();
            n_cmp++; if (rej !== 4'b0010 || gnt !== '0) begin n_bad++; $display("FAIL badlen_rej[%0d]: got rej %b gnt %b want 0010 0000", i, rej, gnt); end
            n_cmp++; if (err !== 2'd1) begin n_bad++; $display("FAIL badlen_err[%0d]: got %0d want 1", i, err); end
            req = '0;
            tick();
            n_cmp++; if (rej !== '0) begin n_bad++; $display("FAIL badlen_rej_width[%0d]: got %b want 0000", i, rej); end
        end
        n_cmp++; if (start_cnt !== sc) begin n_bad++; $display("FAIL badlen_nostart: got %0d starts want 0", start_cnt - sc); end
        len[1*B +: B] = 8'd2;
    endtask

    task automatic test_timeout();
        logic [N-1:0] g, d;
        bit ok;
        int n;
        // Pointer is 2, so client 3 is granted ahead of client 0.
        req = 4'b1001;
        tick();
        n_cmp++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL to_gnt: got %b want 1000", gnt); end
        for (int i = 0; i < 50 && !start; i++) tick();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (rej != '0) break;
        end
        n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL to_latency: got %0d want 16", n); end
        n_cmp++; if (rej !== 4'b1000 || err !== 2'd2) begin n_bad++; $display("FAIL to_rej: got rej %b err %0d want 1000 2", rej, err); end
        req = 4'b0001;
        serve(g, d, ok);
        n_cmp++; if (!ok || g !== 4'b0001 || d !== 4'b0001) begin n_bad++; $display("FAIL to_next: got gnt %b done %b ok %0d want 0001 0001 1", g, d, ok); end
        n_cmp++; if (err !== 2'd2) begin n_bad++; $display("FAIL to_err_hold: got %0d want 2", err); end
        req = '0;
        tick();
    endtask

    task automatic test_busy();
        int sc, dn;
        sc = start_cnt;
        dn = 0;
        busy = 1'b1;
        req = 4'b0010;
        tick();
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL busy_gnt: got %b want 0010", gnt); end
        for (int i = 0; i < 20; i++) begin
            txdone = (i == 10);
            tick();
            if (done_o != '0) dn++;
        end
        txdone = 1'b0;
        n_cmp++; if (start_cnt !== sc || dn !== 0) begin n_bad++; $display("FAIL busy_hold: got starts %0d dones %0d want 0 0", start_cnt - sc, dn); end
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL busy_gnt_hold: got %b want 0010", gnt); end
        busy = 1'b0;
        tick();
        n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL busy_start: got %b want 1", start); end
        tick();
        n_cmp++; if (start !== 1'b0 || start_cnt - sc !== 1) begin n_bad++; $display("FAIL busy_start_once: got start %b count %0d want 0 1", start, start_cnt - sc); end
        txdone = 1'b1;
        tick();
        txdone = 1'b0;
        n_cmp++; if (done_o !== 4'b0010) begin n_bad++; $display("FAIL busy_done: got %b want 0010", done_o); end
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] g, d;
        bit ok;
        req = 4'b0100;
        serve(g, d, ok);
        n_cmp++; if (!ok || g !== 4'b0100 || d !== 4'b0100) begin n_bad++; $display("FAIL rmid_pre: got gnt %b done %b ok %0d want 0100 0100 1", g, d, ok); end
        req = 4'b1000;
        tick();
        for (int i = 0; i < 8 && gnt == '0; i++) tick();
        for (int i = 0; i < 50 && !start; i++) tick();
        repeat (3) tick();
        n_cmp++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL rmid_in_wait: got %b want 1000", gnt); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        req = '0;
        n_cmp++; if ({gnt, done_o, rej, err, start} !== '0) begin n_bad++; $display("FAIL rmid_hs: got %h want 0", {gnt, done_o, rej, err, start}); end
        n_cmp++; if ({topt, tlen, tdata} !== '0) begin n_bad++; $display("FAIL rmid_tx: got %h want 0", {topt, tlen, tdata}); end
        txdone = 1'b1;
        tick();
        txdone = 1'b0;
        n_cmp++; if (done_o !== '0 || rej !== '0) begin n_bad++; $display("FAIL rmid_stray_done: got done %b rej %b want 0000 0000", done_o, rej); end
        tick();
        req = 4'b1101;
        tick();
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL rmid_ptr0: got %b want 0001", gnt); end
        serve(g, d, ok);
        n_cmp++; if (!ok || d !== 4'b0001) begin n_bad++; $display("FAIL rmid_post: got done %b ok %0d want 0001 1", d, ok); end
        req = '0;
        tick();
    endtask

    task automatic test_no_timeout();
        int nr;
        nr = 0;
        req2 = 4'b0001;
        tick();
        n_cmp++; if (gnt2 !== 4'b0001) begin n_bad++; $display("FAIL nto_gnt: got %b want 0001", gnt2); end
        for (int i = 0; i < 50 && !start2; i++) tick();
        n_cmp++; if (start2 !== 1'b1) begin n_bad++; $display("FAIL nto_start: got %b want 1", start2); end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rej2 != '0) nr++;
        end
        n_cmp++; if (nr !== 0 || gnt2 !== 4'b0001) begin n_bad++; $display("FAIL nto_wait: got rej %0d gnt %b want 0 0001", nr, gnt2); end
        txdone2 = 1'b1;
        tick();
        txdone2 = 1'b0;
        n_cmp++; if (done2 !== 4'b0001 || err2 !== 2'd0) begin n_bad++; $display("FAIL nto_done: got done %b err %0d want 0001 0", done2, err2); end
        req2 = '0;
        tick();
    endtask

    initial begin
        RST = 1'b1; req = '0; req2 = '0; busy = 1'b0; txdone = 1'b0; txdone2 = 1'b0;
        for (int k = 0; k < N; k++) begin
            len[k*B +: B]  = 8'd2;
            opt[k*B +: B]  = 8'h10 + 8'(k);
            data[k*D +: D] = {8{8'h30 + 8'(k)}};
        end
        test_reset();
        test_single();
        test_round_robin();
        test_bad_len();
        test_timeout();
        test_busy();
        test_reset_mid();
        test_no_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART frame transmitter among N_CLIENTS requesters. Each client presents a complete frame: option byte, length byte and flat payload. The arbiter grants one client, latches its frame, sequences the transmitter's start/busy/done handshake and reports completion or rejection back to that client. It sits between protocol clients and the tx framer, which handles init pattern, bytes and CRC-32, and mirrors the frame fields produced on the rx side.

Parameters:
N_CLIENTS, 4, number of requesters (>=2)
BYTE_SIZE, 8, bits per byte
MAX_MSG_LEN, 8, max payload bytes per frame
DATA_SIZE, MAX_MSG_LEN*BYTE_SIZE, flat payload width
TIMEOUT_CYCLES, 4096, max cycles waiting for i_tx_done after start; 0 = timeout disabled

Ports:
CLK  in  1  clock; single clock domain
RST  in  1  synchronous reset, active-high
i_req  in  N_CLIENTS  per-client request level
i_opt  in  N_CLIENTS*BYTE_SIZE  client k option at [k*BYTE_SIZE +: BYTE_SIZE]
i_len  in  N_CLIENTS*BYTE_SIZE  client k payload length in bytes
i_data  in  N_CLIENTS*DATA_SIZE  client k payload, first byte in MSBs of its slice
o_gnt  out  N_CLIENTS  one-hot grant
o_done  out  N_CLIENTS  one-cycle pulse: frame sent
o_rej  out  N_CLIENTS  one-cycle pulse: frame rejected or aborted
o_err_code  out  2  cause of last rejection: 0 none, 1 bad length, 2 timeout
o_tx_start  out  1  one-cycle start pulse to framer
o_tx_opt  out  BYTE_SIZE  latched option
o_tx_len  out  BYTE_SIZE  latched length
o_tx_data  out  DATA_SIZE  latched payload
i_tx_busy  in  1  framer busy
i_tx_done  in  1  framer one-cycle completion pulse

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; timeout counter 0. Reset mid-transaction returns to IDLE immediately, with no done or rej pulse.
- States are IDLE, LOAD, START, WAIT, DONE and REJECT. The FSM and all outputs are registered.
- IDLE: if i_req != 0, select the first set bit scanning from pointer upward with wrap. Latch index, set o_gnt one-hot, then go to LOAD. Otherwise stay in IDLE.
- LOAD: copy selected client's opt/len/data into o_tx_* holding registers.
  - If len == 0 or len > MAX_MSG_LEN: go to REJECT with err_code 1.
  - Otherwise go to START.
- START: while i_tx_busy = 1, wait. On the first cycle with i_tx_busy = 0, assert o_tx_start for exactly one cycle, clear the counter and go to WAIT. i_tx_done in START is ignored.
- WAIT: counter increments each cycle.
  - i_tx_done = 1: go to DONE.
  - Else if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: go to REJECT with err_code 2.
  - If done and expiry occur in the same cycle, done wins.
- DONE: o_gnt goes 0, o_done[idx] pulses for one cycle, pointer becomes (idx+1) mod N_CLIENTS, next state IDLE.
- REJECT: o_gnt goes 0, o_rej[idx] pulses for one cycle, o_err_code is updated and held until the next rejection. Pointer becomes (idx+1) mod N_CLIENTS; next state IDLE.
- o_gnt is high in LOAD, START and WAIT only. At most one bit of o_gnt, o_done or o_rej is set at any time.
- o_tx_opt, o_tx_len and o_tx_data stay stable from LOAD until the next LOAD.
- Client contract: hold i_req and payload until o_done or o_rej. Deasserting i_req mid-transaction does not cancel it. A new request is accepted no earlier than the IDLE cycle after the terminal pulse.
- Latency: i_req seen in IDLE at cycle t gives o_gnt at t+1 and o_tx_start at t+3 at the earliest (busy = 0). The terminal pulse comes in the cycle after i_tx_done is sampled.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1. Pointer width is $clog2(N_CLIENTS).

Test Plan:
- Single client 2, len=3, data=0x112233, busy=0, done 10 cycles after start -> o_gnt=4'b0100, tx_len=3, one start pulse, o_done[2] pulse, pointer=3.
- Clients 0,1,3 request continuously, pointer=0 -> grant order 0,1,3,0,1,3. No client is granted twice while another is pending.
- Client 1 len=0, then client 1 len=9 (MAX=8) -> o_rej[1] each time, err_code=1, o_tx_start never asserted.
- TIMEOUT_CYCLES=16, i_tx_done never arrives -> o_rej pulse 16 cycles after WAIT entry, err_code=2, then next requester granted. Same with TIMEOUT_CYCLES=0 -> waits indefinitely.
- i_tx_busy held 1 for 20 cycles in START -> start pulse only on the first cycle busy=0. i_tx_done pulsed during START -> ignored.
- RST asserted during WAIT -> next cycle all outputs 0, state IDLE, pointer 0. A later done pulse on i_tx_done produces no o_done.
